// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the CPU pipeline: word/register widths, ALU opcodes,
// branch kinds, execute-stage FSM states and the EX/MEM pipeline register layout.
package cpu_types_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_EQ   = 2'd1,
    BR_NE   = 2'd2
  } brtype_t;

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } exstate_t;

  typedef struct packed {
    logic     valid;
    logic     regwen;
    logic     memread;
    logic     memwrite;
    word_t    result;
    word_t    storedata;
    regbits_t rd;
    logic     zero;
    logic     negative;
    logic     brtaken;
    word_t    brtarget;
  } exmem_t;

  function automatic logic branch_taken(input brtype_t br, input logic zero);
    return ((br == BR_EQ) && zero) || ((br == BR_NE) && !zero);
  endfunction

endpackage

// File: rtl/alu_if.sv
// Connection bundle between the execute stage and the combinational ALU.
interface alu_if;
  import cpu_types_pkg::*;

  aluop_t aluop;
  word_t  port_a;
  word_t  port_b;
  word_t  port_out;
  logic   negative;
  logic   overflow;
  logic   zero;

  modport alu (input aluop, port_a, port_b, output port_out, negative, overflow, zero);
  modport ex  (output aluop, port_a, port_b, input port_out, negative, overflow, zero);
endinterface

// File: rtl/alu.sv
// Combinational ALU. Shifts move port_b by port_a[4:0]; overflow is signed and
// only meaningful for ADD/SUB.
module alu
  import cpu_types_pkg::*;
(
  alu_if.alu aluif
);

  word_t a;
  word_t b;
  word_t result;
  logic  ovf;

  assign a = aluif.port_a;
  assign b = aluif.port_b;

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (aluif.aluop)
      ALU_SLL:  result = b << a[4:0];
      ALU_SRL:  result = b >> a[4:0];
      ALU_ADD: begin
        result = a + b;
        ovf    = (a[31] == b[31]) && (result[31] != a[31]);
      end
      ALU_SUB: begin
        result = a - b;
        ovf    = (a[31] != b[31]) && (result[31] != a[31]);
      end
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: result = {31'b0, a < b};
      default:  result = '0;
    endcase
  end

  assign aluif.port_out = result;
  assign aluif.overflow = ovf;
  assign aluif.zero     = (result == '0);
  assign aluif.negative = result[31];

endmodule

// File: rtl/forward_unit.sv
// Operand forwarding (EX/MEM over MEM/WB over register file) and load-use
// hazard detection for the execute stage.
module forward_unit
  import cpu_types_pkg::*;
(
  input  regbits_t id_rs,
  input  regbits_t id_rt,
  input  logic     id_alusrc,
  input  word_t    id_rs_data,
  input  word_t    id_rt_data,
  input  logic     exm_valid,
  input  logic     exm_regwen,
  input  logic     exm_memread,
  input  regbits_t exm_rd,
  input  word_t    exm_result,
  input  logic     wb_regwen,
  input  regbits_t wb_rd,
  input  word_t    wb_data,
  output word_t    fwd_rs,
  output word_t    fwd_rt,
  output logic     loaduse
);

  logic exm_fwd_ok;
  logic load_pending;

  // A load in EX/MEM has no data yet, so it can never be a forwarding source.
  assign exm_fwd_ok   = exm_valid && exm_regwen && !exm_memread;
  assign load_pending = exm_valid && exm_memread && (exm_rd != '0);

  function automatic word_t pick(input regbits_t src, input word_t rf_data,
                                 input logic exm_ok, input regbits_t e_rd,
                                 input word_t e_res, input logic w_en,
                                 input regbits_t w_rd, input word_t w_data);
    if (exm_ok && (e_rd == src) && (src != '0))
      return e_res;
    else if (w_en && (w_rd == src) && (src != '0))
      return w_data;
    else
      return rf_data;
  endfunction

  assign fwd_rs = pick(id_rs, id_rs_data, exm_fwd_ok, exm_rd, exm_result,
                       wb_regwen, wb_rd, wb_data);
  assign fwd_rt = pick(id_rt, id_rt_data, exm_fwd_ok, exm_rd, exm_result,
                       wb_regwen, wb_rd, wb_data);

  assign loaduse = load_pending &&
                   ((exm_rd == id_rs) || ((exm_rd == id_rt) && !id_alusrc));

endmodule

// File: rtl/execute_stage.sv
// Execute stage: forwards operands, drives the ALU, resolves branches and
// overflow traps, and owns the EX/MEM register and the decode/memory handshake.
//
//   state | meaning
//   RUN   | normal issue; overflow on a checked op moves to TRAP
//   TRAP  | trap pending; decode is drained, every write is a bubble until flush
module execute_stage
  import cpu_types_pkg::*;
(
  input  logic     CLK,
  input  logic     nRST,
  input  logic     id_valid,
  input  aluop_t   id_aluop,
  input  word_t    id_rs_data,
  input  word_t    id_rt_data,
  input  word_t    id_imm,
  input  regbits_t id_shamt,
  input  regbits_t id_rs,
  input  regbits_t id_rt,
  input  regbits_t id_rd,
  input  logic     id_alusrc,
  input  logic     id_shift,
  input  logic     id_regwen,
  input  logic     id_memread,
  input  logic     id_memwrite,
  input  logic     id_chkovf,
  input  brtype_t  id_br,
  input  word_t    id_brtarget,
  output logic     ex_ready,
  input  logic     mem_stall,
  input  logic     flush,
  input  logic     wb_regwen,
  input  regbits_t wb_rd,
  input  word_t    wb_data,
  output logic     exm_valid,
  output logic     exm_regwen,
  output logic     exm_memread,
  output logic     exm_memwrite,
  output word_t    exm_result,
  output word_t    exm_storedata,
  output regbits_t exm_rd,
  output logic     exm_zero,
  output logic     exm_negative,
  output logic     exm_brtaken,
  output word_t    exm_brtarget,
  output logic     exception
);

  exstate_t state;
  exstate_t next_state;
  exmem_t   exm;
  exmem_t   exm_next;
  word_t    fwd_rs;
  word_t    fwd_rt;
  logic     loaduse;
  logic     trap_now;
  logic     write_instr;

  alu_if aluif ();

  alu u_alu (
    .aluif (aluif)
  );

  forward_unit u_fwd (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_alusrc   (id_alusrc),
    .id_rs_data  (id_rs_data),
    .id_rt_data  (id_rt_data),
    .exm_valid   (exm.valid),
    .exm_regwen  (exm.regwen),
    .exm_memread (exm.memread),
    .exm_rd      (exm.rd),
    .exm_result  (exm.result),
    .wb_regwen   (wb_regwen),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .fwd_rs      (fwd_rs),
    .fwd_rt      (fwd_rt),
    .loaduse     (loaduse)
  );

  assign aluif.aluop  = id_aluop;
  assign aluif.port_a = id_shift ? {27'b0, id_shamt} : fwd_rs;
  assign aluif.port_b = id_alusrc ? id_imm : fwd_rt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      state <= RUN;
    else
      state <= next_state;
  end

  // trap_now already implies an accepted instruction, so no stall check here.
  always_comb begin
    next_state = state;
    if (flush)
      next_state = RUN;
    else if (trap_now)
      next_state = TRAP;
  end

  always_comb begin
    ex_ready    = 1'b0;
    trap_now    = 1'b0;
    write_instr = 1'b0;
    case (state)
      RUN: begin
        ex_ready    = !mem_stall && !loaduse;
        trap_now    = id_valid && ex_ready && id_chkovf && aluif.overflow;
        write_instr = id_valid && ex_ready && !trap_now;
      end
      TRAP:    ex_ready = !mem_stall;
      default: ex_ready = 1'b0;
    endcase
  end

  always_comb begin
    exm_next           = '0;
    exm_next.valid     = 1'b1;
    exm_next.regwen    = id_regwen;
    exm_next.memread   = id_memread;
    exm_next.memwrite  = id_memwrite;
    exm_next.result    = aluif.port_out;
    exm_next.storedata = fwd_rt;
    exm_next.rd        = id_rd;
    exm_next.zero      = aluif.zero;
    exm_next.negative  = aluif.negative;
    exm_next.brtaken   = branch_taken(id_br, aluif.zero);
    exm_next.brtarget  = id_brtarget;
  end

  // Flush wins over stall; an unstalled cycle without a real write is a bubble.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      exm <= '0;
    else if (flush)
      exm <= '0;
    else if (write_instr)
      exm <= exm_next;
    else if (!mem_stall)
      exm <= '0;
  end

  assign exm_valid     = exm.valid;
  assign exm_regwen    = exm.regwen;
  assign exm_memread   = exm.memread;
  assign exm_memwrite  = exm.memwrite;
  assign exm_result    = exm.result;
  assign exm_storedata = exm.storedata;
  assign exm_rd        = exm.rd;
  assign exm_zero      = exm.zero;
  assign exm_negative  = exm.negative;
  assign exm_brtaken   = exm.brtaken;
  assign exm_brtarget  = exm.brtarget;
  assign exception     = (state == TRAP);

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: a vector table feeds a scoreboard checked one cycle
// later, plus hand-written stall, flush and reset-in-flight sequences.
module tb_execute_stage;
  import cpu_types_pkg::*;

  logic     CLK = 1'b0;
  logic     nRST;
  logic     id_valid;
  aluop_t   id_aluop;
  word_t    id_rs_data, id_rt_data, id_imm, id_brtarget, wb_data;
  regbits_t id_shamt, id_rs, id_rt, id_rd, wb_rd;
  logic     id_alusrc, id_shift, id_regwen, id_memread, id_memwrite, id_chkovf;
  brtype_t  id_br;
  logic     ex_ready, mem_stall, flush, wb_regwen;
  logic     exm_valid, exm_regwen, exm_memread, exm_memwrite;
  word_t    exm_result, exm_storedata, exm_brtarget;
  regbits_t exm_rd;
  logic     exm_zero, exm_negative, exm_brtaken, exception;

  execute_stage dut (
    .CLK(CLK), .nRST(nRST), .id_valid(id_valid), .id_aluop(id_aluop),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_alusrc(id_alusrc), .id_shift(id_shift), .id_regwen(id_regwen),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .id_chkovf(id_chkovf),
    .id_br(id_br), .id_brtarget(id_brtarget), .ex_ready(ex_ready),
    .mem_stall(mem_stall), .flush(flush), .wb_regwen(wb_regwen), .wb_rd(wb_rd),
    .wb_data(wb_data), .exm_valid(exm_valid), .exm_regwen(exm_regwen),
    .exm_memread(exm_memread), .exm_memwrite(exm_memwrite),
    .exm_result(exm_result), .exm_storedata(exm_storedata), .exm_rd(exm_rd),
    .exm_zero(exm_zero), .exm_negative(exm_negative), .exm_brtaken(exm_brtaken),
    .exm_brtarget(exm_brtarget), .exception(exception)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic     valid;
    aluop_t   op;
    regbits_t rs, rt, rd;
    word_t    rsd, rtd, imm;
    logic     alusrc, regwen, memread, chkovf;
    brtype_t  br;
    logic     wbr;
    regbits_t wbrd;
    word_t    wbd;
    logic     flush;
    logic     e_ready, e_valid;
    word_t    e_result;
    logic     e_brt, e_exc;
  } vec_t;

  typedef struct {
    logic     valid;
    word_t    result;
    regbits_t rd;
    logic     brt;
    word_t    brtarget;
    logic     exc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  exp_t cur;
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int valid, input aluop_t op, input int rs,
                              input int rt, input int rd, input word_t rsd,
                              input word_t rtd, input word_t imm, input int alusrc,
                              input int regwen, input int memread, input int chkovf,
                              input brtype_t br, input int wbr, input int wbrd,
                              input word_t wbd, input int fl, input int e_ready,
                              input int e_valid, input word_t e_result,
                              input int e_brt, input int e_exc);
    vec_t v;
    v.valid = (valid != 0);   v.op = op;
    v.rs = 5'(rs);            v.rt = 5'(rt);          v.rd = 5'(rd);
    v.rsd = rsd;              v.rtd = rtd;            v.imm = imm;
    v.alusrc = (alusrc != 0); v.regwen = (regwen != 0);
    v.memread = (memread != 0); v.chkovf = (chkovf != 0);
    v.br = br;                v.wbr = (wbr != 0);     v.wbrd = 5'(wbrd);
    v.wbd = wbd;              v.flush = (fl != 0);
    v.e_ready = (e_ready != 0); v.e_valid = (e_valid != 0);
    v.e_result = e_result;    v.e_brt = (e_brt != 0); v.e_exc = (e_exc != 0);
    return v;
  endfunction

  task automatic idle();
    id_valid = 0; id_aluop = ALU_ADD; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    id_shamt = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_alusrc = 0; id_shift = 0;
    id_regwen = 0; id_memread = 0; id_memwrite = 0; id_chkovf = 0; id_br = BR_NONE;
    id_brtarget = 0; mem_stall = 0; flush = 0; wb_regwen = 0; wb_rd = 0; wb_data = 0;
  endtask

  task automatic apply(input vec_t v, input word_t brt);
    idle();
    id_valid = v.valid; id_aluop = v.op; id_rs = v.rs; id_rt = v.rt; id_rd = v.rd;
    id_rs_data = v.rsd; id_rt_data = v.rtd; id_imm = v.imm; id_alusrc = v.alusrc;
    id_regwen = v.regwen; id_memread = v.memread; id_chkovf = v.chkovf; id_br = v.br;
    id_brtarget = brt; wb_regwen = v.wbr; wb_rd = v.wbrd; wb_data = v.wbd;
    flush = v.flush;
  endtask

  task automatic chk_reset(input string tag);
    check1({tag, "_valid"}, exm_valid, 1'b0);
    check1({tag, "_regwen"}, exm_regwen, 1'b0);
    check1({tag, "_memread"}, exm_memread, 1'b0);
    check1({tag, "_memwrite"}, exm_memwrite, 1'b0);
    check32({tag, "_result"}, exm_result, 32'h0);
    check32({tag, "_storedata"}, exm_storedata, 32'h0);
    check32({tag, "_rd"}, 32'(exm_rd), 32'h0);
    check1({tag, "_zero"}, exm_zero, 1'b0);
    check1({tag, "_negative"}, exm_negative, 1'b0);
    check1({tag, "_brtaken"}, exm_brtaken, 1'b0);
    check32({tag, "_brtarget"}, exm_brtarget, 32'h0);
    check1({tag, "_exception"}, exception, 1'b0);
  endtask

  // Scoreboard: one entry per driven cycle, compared at the following falling edge.
  always @(negedge CLK) begin
    if (mon_en && sb.size() > 0) begin
      cur = sb.pop_front();
      check1("sb_valid", exm_valid, cur.valid);
      check1("sb_exception", exception, cur.exc);
      if (cur.valid) begin
        check32("sb_result", exm_result, cur.result);
        check32("sb_rd", 32'(exm_rd), 32'(cur.rd));
        check1("sb_brtaken", exm_brtaken, cur.brt);
        if (cur.brt)
          check32("sb_brtarget", exm_brtarget, cur.brtarget);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    word_t brt;
    //                 v op       rs rt rd rsd           rtd           imm src wen mrd ovf br       wbr wrd wbd flush rdy vld result        brt exc
    vecs.push_back(mk(1, ALU_ADD, 1, 2, 3, 5,           7,            0, 0,  1,  0,  1,  BR_NONE, 0,  0,  0,   0,  1,  1,  12,           0,  0));
    vecs.push_back(mk(1, ALU_SUB, 3, 1, 4, 0,           5,            0, 0,  1,  0,  1,  BR_NONE, 0,  0,  0,   0,  1,  1,  7,            0,  0));
    vecs.push_back(mk(1, ALU_ADD, 1, 5, 5, 5,           0,            4, 1,  1,  1,  0,  BR_NONE, 0,  0,  0,   0,  1,  1,  9,            0,  0));
    vecs.push_back(mk(1, ALU_ADD, 5, 5, 6, 0,           0,            0, 0,  1,  0,  1,  BR_NONE, 0,  0,  0,   0,  0,  0,  0,            0,  0));
    vecs.push_back(mk(1, ALU_ADD, 5, 5, 6, 0,           0,            0, 0,  1,  0,  1,  BR_NONE, 1,  5,  9,   0,  1,  1,  18,           0,  0));
    vecs.push_back(mk(1, ALU_ADD, 7, 0, 8, 32'h7FFFFFFF, 0,           1, 1,  1,  0,  0,  BR_NONE, 0,  0,  0,   0,  1,  1,  32'h80000000, 0,  0));
    vecs.push_back(mk(1, ALU_SUB, 8, 9, 0, 0,           32'h80000000, 0, 0,  0,  0,  0,  BR_EQ,   0,  0,  0,   0,  1,  1,  0,            1,  0));
    vecs.push_back(mk(1, ALU_SUB, 8, 9, 0, 32'h80000000, 32'h80000000, 0, 0, 0,  0,  0,  BR_NE,   0,  0,  0,   0,  1,  1,  0,            0,  0));
    vecs.push_back(mk(0, ALU_ADD, 0, 0, 0, 0,           0,            0, 0,  0,  0,  0,  BR_NONE, 0,  0,  0,   0,  1,  0,  0,            0,  0));
    vecs.push_back(mk(1, ALU_ADD, 7, 0, 10, 32'h7FFFFFFF, 0,          1, 1,  1,  0,  1,  BR_NONE, 0,  0,  0,   0,  1,  0,  0,            0,  1));
    vecs.push_back(mk(1, ALU_ADD, 1, 2, 11, 5,          7,            0, 0,  1,  0,  1,  BR_NONE, 0,  0,  0,   0,  1,  0,  0,            0,  1));
    vecs.push_back(mk(1, ALU_ADD, 1, 2, 11, 5,          7,            0, 0,  1,  0,  1,  BR_NONE, 0,  0,  0,   1,  1,  0,  0,            0,  0));
    vecs.push_back(mk(1, ALU_ADD, 1, 2, 11, 5,          7,            0, 0,  1,  0,  1,  BR_NONE, 1,  1,  100, 0,  1,  1,  107,          0,  0));
    vecs.push_back(mk(1, ALU_ADD, 11, 0, 12, 0,         0,            0, 0,  1,  0,  1,  BR_NONE, 1,  11, 999, 0,  1,  1,  107,          0,  0));
    vecs.push_back(mk(1, ALU_ADD, 1, 5, 5, 5,           0,            4, 1,  1,  1,  0,  BR_NONE, 0,  0,  0,   0,  1,  1,  9,            0,  0));
    vecs.push_back(mk(1, ALU_ADD, 1, 5, 13, 5,          0,            3, 1,  1,  0,  0,  BR_NONE, 0,  0,  0,   0,  1,  1,  8,            0,  0));
    vecs.push_back(mk(0, ALU_ADD, 0, 0, 0, 0,           0,            0, 0,  0,  0,  0,  BR_NONE, 0,  0,  0,   0,  1,  0,  0,            0,  0));

    nRST = 1'b0;
    idle();
    #12;
    chk_reset("por");
    check1("por_ex_ready", ex_ready, 1'b1);
    @(negedge CLK);
    nRST = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge CLK);
      brt = 32'h1000 + 32'(i * 4);
      apply(vecs[i], brt);
      #1;
      check1($sformatf("ready[%0d]", i), ex_ready, vecs[i].e_ready);
      sb.push_back('{vecs[i].e_valid, vecs[i].e_result, vecs[i].rd,
                     vecs[i].e_brt, brt, vecs[i].e_exc});
    end
    @(negedge CLK);
    idle();
    @(negedge CLK);
    @(negedge CLK);
    check32("sb_drained", 32'(sb.size()), 32'h0);
    mon_en = 1'b0;

    // mem_stall held three cycles with a valid instruction waiting, then flushed.
    @(negedge CLK);
    apply(mk(1, ALU_ADD, 1, 2, 3, 5, 7, 0, 0, 1, 0, 1, BR_NONE, 0, 0, 0, 0, 1, 1, 12, 0, 0), 32'h0);
    @(negedge CLK);
    apply(mk(1, ALU_SUB, 3, 1, 4, 0, 5, 0, 0, 1, 0, 1, BR_NONE, 0, 0, 0, 0, 0, 0, 0, 0, 0), 32'h0);
    mem_stall = 1'b1;
    #1;
    check1("stall_ready", ex_ready, 1'b0);
    check32("stall_pre_result", exm_result, 32'd12);
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK);
      #1;
      check1($sformatf("stall_valid[%0d]", k), exm_valid, 1'b1);
      check32($sformatf("stall_result[%0d]", k), exm_result, 32'd12);
      check32($sformatf("stall_rd[%0d]", k), 32'(exm_rd), 32'd3);
      check1($sformatf("stall_ready[%0d]", k), ex_ready, 1'b0);
    end
    @(negedge CLK);
    flush = 1'b1;
    @(posedge CLK);
    #1;
    check1("flush_in_stall_valid", exm_valid, 1'b0);
    check1("flush_in_stall_regwen", exm_regwen, 1'b0);

    // Reset pulled mid-cycle while stalled with a live instruction in EX/MEM.
    @(negedge CLK);
    apply(mk(1, ALU_ADD, 1, 2, 3, 5, 7, 0, 0, 1, 0, 1, BR_NONE, 0, 0, 0, 0, 1, 1, 12, 0, 0), 32'h0);
    @(posedge CLK);
    #1;
    check32("pre_reset_result", exm_result, 32'd12);
    @(negedge CLK);
    mem_stall = 1'b1;
    #2;
    nRST = 1'b0;
    #1;
    chk_reset("rst_stall");
    mem_stall = 1'b0;
    #1;
    check1("rst_stall_ready", ex_ready, 1'b1);
    @(negedge CLK);
    nRST = 1'b1;

    // Reset pulled mid-cycle while trapped and stalled.
    @(negedge CLK);
    apply(mk(1, ALU_ADD, 7, 0, 10, 32'h7FFFFFFF, 0, 1, 1, 1, 0, 1, BR_NONE, 0, 0, 0, 0, 1, 0, 0, 0, 1), 32'h0);
    @(posedge CLK);
    #1;
    check1("trap_exception", exception, 1'b1);
    check1("trap_valid", exm_valid, 1'b0);
    @(negedge CLK);
    mem_stall = 1'b1;
    #2;
    nRST = 1'b0;
    #1;
    chk_reset("rst_trap");
    mem_stall = 1'b0;
    #1;
    check1("rst_trap_ready", ex_ready, 1'b1);
    @(negedge CLK);
    nRST = 1'b1;
    idle();
    @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
